// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants for the register-file writeback path.
//   ADDR_W   : register address width (32 registers)
//   DATA_W   : register data width
//   ZERO_REG : index of the hardwired-zero register (writes to it are dropped)
//   NUM_REGS : number of architectural registers
//   GID_W    : width of the grant_id output (supports up to 8 requesters)
//   CNT_W    : width of the committed-write counter
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int ZERO_REG = 0;
    localparam int NUM_REGS = 32;
    localparam int GID_W    = 3;
    localparam int CNT_W    = 16;

    typedef logic [GID_W-1:0] gid_t;
    typedef logic [CNT_W-1:0] wr_count_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational rotate-priority picker. The search starts at rr_ptr+1 and
//   wraps modulo N; the first requesting index wins.
//   Ports:
//     req       in   N      request vector
//     rr_ptr    in   3      index of the last winner
//     grant     out  N      one-hot grant (all zero when no request)
//     grant_idx out  3      encoded index of the winner (0 when no request)
//     any_grant out  1      at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [GID_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [GID_W-1:0] grant_idx,
    output logic             any_grant
);

    int best_dist;
    int best_idx;

    // Distance of index i from the search start (rr_ptr+1), modulo N.
    // The requesting index with the smallest distance wins.
    always_comb begin
        best_dist = N;
        best_idx  = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (((i + 2 * N - int'(rr_ptr) - 1) % N) < best_dist)) begin
                best_dist = (i + 2 * N - int'(rr_ptr) - 1) % N;
                best_idx  = i;
            end
        end
    end

    assign any_grant = |req;
    assign grant_idx = any_grant ? GID_W'(best_idx) : '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = any_grant && (best_idx == gi);
        end
    endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port among NREQ writeback sources
//   with round-robin arbitration and a valid/ready handshake per source. The
//   write port is driven from a registered output stage.
//   Ports:
//     clk        in   1            rising-edge clock
//     rst        in   1            asynchronous active-high reset
//     req_valid  in   NREQ         requester i has a write pending
//     req_addr   in   NREQ*ADDR_W  dest reg of requester i
//     req_data   in   NREQ*DATA_W  write data of requester i
//     req_ready  out  NREQ         one-hot accept
//     rf_hold    in   1            freeze the write port, pending write held
//     rf_we      out  1            register-file write enable
//     rf_waddr   out  ADDR_W       register-file write address
//     rf_wdata   out  DATA_W       register-file write data
//     grant_id   out  3            requester whose write is on the port
//     wr_count   out  16           committed writes, wraps at 2^16
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     rf_hold,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [GID_W-1:0]         grant_id,
    output logic [CNT_W-1:0]         wr_count
);

    // Output stage and arbitration state
    logic              out_valid_reg;
    logic [ADDR_W-1:0] rf_waddr_reg;
    logic [DATA_W-1:0] rf_wdata_reg;
    gid_t              grant_id_reg;
    gid_t              rr_ptr_reg;
    wr_count_t         wr_count_reg;

    // Arbiter results
    logic [NREQ-1:0]   arb_grant;
    gid_t              arb_idx;
    logic              arb_any;

    logic              can_accept;
    logic              transfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Unpacked views of the flattened request buses
    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // The stage can take a new write when it is empty or when it drains this
    // cycle (hold released). A held, occupied stage blocks all requesters.
    assign can_accept = ~out_valid_reg | ~rf_hold;
    assign transfer   = arb_any & can_accept;
    assign req_ready  = rst ? '0 : (arb_grant & {NREQ{can_accept}});

    // AND-OR mux over the one-hot grant avoids an index of mismatched width.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = sel_addr | addr_arr[i];
                sel_data = sel_data | data_arr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            grant_id_reg  <= '0;
            rr_ptr_reg    <= GID_W'(NREQ - 1);
            wr_count_reg  <= '0;
        end else begin
            if (transfer) begin
                out_valid_reg <= 1'b1;
                rf_waddr_reg  <= sel_addr;
                rf_wdata_reg  <= sel_data;
                grant_id_reg  <= arb_idx;
                rr_ptr_reg    <= arb_idx;
            end else if (!rf_hold) begin
                out_valid_reg <= 1'b0;
            end

            if (rf_we) begin
                wr_count_reg <= wr_count_reg + 1'b1;
            end
        end
    end

    // Writes to the zero register occupy the stage but never reach the file.
    assign rf_we    = out_valid_reg & ~rf_hold & (rf_waddr_reg != ADDR_W'(ZERO_REG));
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign grant_id = grant_id_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;

    logic                     clk;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     rf_hold;
    logic                     rf_we;
    logic [ADDR_W-1:0]        rf_waddr;
    logic [DATA_W-1:0]        rf_wdata;
    logic [GID_W-1:0]         grant_id;
    logic [CNT_W-1:0]         wr_count;

    int errors;
    int checks;

    regfile_wb_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_hold   (rf_hold),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        bit reached;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        rf_hold   = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;

        // Reset state: outputs cleared and all ready gated off during reset
        #2;
        check("reset_rf_we",     32'(rf_we),     32'd0);
        check("reset_rf_waddr",  32'(rf_waddr),  32'd0);
        check("reset_rf_wdata",  rf_wdata,       32'd0);
        check("reset_grant_id",  32'(grant_id),  32'd0);
        check("reset_wr_count",  32'(wr_count),  32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        $display("reset: rf_we=%0d wr_count=%0d req_ready=%b", rf_we, wr_count, req_ready);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1;

        // Single source: req0 -> reg 5 = DEADBEEF
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b001;
        #1;
        check("single_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        check("single_we",    32'(rf_we),    32'd1);
        check("single_waddr", 32'(rf_waddr), 32'd5);
        check("single_wdata", rf_wdata,      32'hDEAD_BEEF);
        check("single_gid",   32'(grant_id), 32'd0);
        $display("single: we=%0d waddr=%0d wdata=%h gid=%0d", rf_we, rf_waddr, rf_wdata, grant_id);
        tick();
        check("single_count", 32'(wr_count), 32'd1);
        check("single_idle",  32'(rf_we),    32'd0);

        // Lone req2 write moves rr_ptr to 2 so the next sweep starts at 0
        set_req(2, 5'd7, 32'h0000_0777);
        req_valid = 3'b100;
        #1;
        check("pre_rr_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        check("pre_rr_we", 32'(rf_we), 32'd1);
        tick();
        check("pre_rr_count", 32'(wr_count), 32'd2);

        // Round robin: all three valid -> 0,1,2,0,1,2 and one write per cycle
        set_req(0, 5'd1, 32'h1111_1111);
        set_req(1, 5'd2, 32'h2222_2222);
        set_req(2, 5'd3, 32'h3333_3333);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
            tick();
            if (k == 5) req_valid = '0;
            check("rr_gid",   32'(grant_id), 32'(k % 3));
            check("rr_we",    32'(rf_we),    32'd1);
            check("rr_waddr", 32'(rf_waddr), 32'(k % 3 + 1));
            check("rr_count", 32'(wr_count), 32'(2 + k));
            $display("rr step %0d: gid=%0d we=%0d waddr=%0d count=%0d", k, grant_id, rf_we, rf_waddr, wr_count);
        end
        tick();
        check("rr_count_final", 32'(wr_count), 32'd8);

        // Zero register: accepted, occupies the stage, no write
        set_req(1, 5'd0, 32'h0000_1234);
        req_valid = 3'b010;
        #1;
        check("zero_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        check("zero_we",    32'(rf_we),    32'd0);
        check("zero_gid",   32'(grant_id), 32'd1);
        check("zero_waddr", 32'(rf_waddr), 32'd0);
        check("zero_wdata", rf_wdata,      32'h0000_1234);
        $display("zero: we=%0d gid=%0d waddr=%0d count=%0d", rf_we, grant_id, rf_waddr, wr_count);
        tick();
        check("zero_count", 32'(wr_count), 32'd8);

        // Hold: pending req2 write frozen for 4 cycles while req0 waits
        set_req(2, 5'd9, 32'hAAAA_5555);
        req_valid = 3'b100;
        #1;
        check("hold_load_ready", 32'(req_ready), 32'b100);
        tick();
        rf_hold = 1'b1;
        set_req(0, 5'd10, 32'h0F0F_0F0F);
        req_valid = 3'b001;
        for (int h = 0; h < 4; h++) begin
            #1;
            check("hold_we",    32'(rf_we),     32'd0);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_waddr", 32'(rf_waddr),  32'd9);
            check("hold_wdata", rf_wdata,       32'hAAAA_5555);
            check("hold_gid",   32'(grant_id),  32'd2);
            check("hold_count", 32'(wr_count),  32'd8);
            $display("hold cycle %0d: we=%0d ready=%b waddr=%0d", h, rf_we, req_ready, rf_waddr);
            tick();
        end
        rf_hold = 1'b0;
        #1;
        check("release_we",    32'(rf_we),     32'd1);
        check("release_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        check("release_count", 32'(wr_count), 32'd9);
        check("release_gid",   32'(grant_id), 32'd0);
        check("release_waddr", 32'(rf_waddr), 32'd10);
        check("release_we2",   32'(rf_we),    32'd1);
        tick();
        check("release_count2", 32'(wr_count), 32'd10);

        // Reset mid-operation with a held pending write
        rf_hold = 1'b1;
        set_req(1, 5'd3, 32'h0000_0077);
        req_valid = 3'b010;
        #1;
        check("rst_load_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b001;
        check("rst_pending_we",    32'(rf_we),    32'd0);
        check("rst_pending_waddr", 32'(rf_waddr), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_we",    32'(rf_we),     32'd0);
        check("rst_mid_count", 32'(wr_count),  32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd0);
        check("rst_mid_waddr", 32'(rf_waddr),  32'd0);
        $display("mid reset: we=%0d count=%0d ready=%b", rf_we, wr_count, req_ready);
        tick();
        rst       = 1'b0;
        rf_hold   = 1'b0;
        req_valid = '0;
        #1;
        check("post_rst_we", 32'(rf_we), 32'd0);
        tick();
        check("post_rst_count", 32'(wr_count), 32'd0);
        // rr_ptr back at NREQ-1: requester 0 wins with all valid
        set_req(0, 5'd4, 32'h0000_0044);
        req_valid = 3'b111;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        check("post_rst_gid", 32'(grant_id), 32'd0);
        tick();
        check("post_rst_count2", 32'(wr_count), 32'd1);

        // Counter wrap: stream req0 writes until 16'hFFFF, then one more
        req_valid = 3'b001;
        reached   = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            tick();
            if (wr_count == 16'hFFFE) begin
                reached = 1'b1;
                break;
            end
        end
        req_valid = '0;
        check("wrap_reached", 32'(reached), 32'd1);
        tick();
        check("wrap_ffff", 32'(wr_count), 32'h0000_FFFF);
        check("wrap_idle", 32'(rf_we),    32'd0);
        req_valid = 3'b001;
        #1;
        check("wrap_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        check("wrap_we", 32'(rf_we), 32'd1);
        tick();
        check("wrap_zero", 32'(wr_count), 32'd0);
        $display("wrap: wr_count=%0h", wr_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
